// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, FSM states
// and the bitwise helper functions used by the round and schedule logic.
package sha256_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } work_t;

   // Padded single-block message for "abc" (24-bit length in the last word)
   localparam logic [511:0] ABC_BLOCK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic work_t iv_work();
      return '{a: IV[0], b: IV[1], c: IV[2], d: IV[3],
               e: IV[4], f: IV[5], g: IV[6], h: IV[7]};
   endfunction

   function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                      input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   // bsig* are the upper-case Sigma functions (round), ssig* the lower-case sigma (schedule)
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return ror32(x, 2) ^ ror32(x, 13) ^ ror32(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return ror32(x, 6) ^ ror32(x, 11) ^ ror32(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_hash_if.sv
// Output bundle of the hash engine: digest words, working variables and FSM debug view.
// There is no valid/ready handshake: the digest is valid once state reads DONE.
interface sha256_hash_if;
   import sha256_pkg::*;

   logic [31:0] h1, h2, h3, h4, h5, h6, h7, h8;
   logic [31:0] a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
   state_t      state;
   logic [5:0]  round_cnt;

   modport master (
      output h1, h2, h3, h4, h5, h6, h7, h8,
      output a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out,
      output state, round_cnt
   );

   modport slave (
      input h1, h2, h3, h4, h5, h6, h7, h8,
      input a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out,
      input state, round_cnt
   );

endinterface

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational: working variables in, next set out.
module sha256_round
   import sha256_pkg::*;
(
   input  work_t       cur,
   input  logic [31:0] k,
   input  logic [31:0] w,
   output work_t       nxt
);

   logic [31:0] t1;
   logic [31:0] t2;

   always_comb begin
      t1 = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
      t2 = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);
      nxt.a = t1 + t2;
      nxt.b = cur.a;
      nxt.c = cur.b;
      nxt.d = cur.c;
      nxt.e = cur.d + t1;
      nxt.f = cur.e;
      nxt.g = cur.f;
      nxt.h = cur.g;
   end

endmodule

// File: rtl/sha256_hash_top.sv
// Iterative SHA-256 engine hashing a fixed block after reset, one round per clock.
// Define SHA256_DOUBLE_HASH_EN to rehash the digest (SHA-256d) before reaching DONE.
module sha256_hash_top
   import sha256_pkg::*;
#(
   parameter logic [511:0] MSG_BLOCK = ABC_BLOCK
)(
   input  logic clk,
   input  logic rst,
   sha256_hash_if.master bus
);

   state_t      state;
   logic [5:0]  ctr;
   work_t       work;
   work_t       work_nxt;
   logic [31:0] h_reg [8];
   logic [31:0] w_win [16];
   logic [31:0] w_new;
   logic [511:0] load_block;

`ifdef SHA256_DOUBLE_HASH_EN
   logic pass2;

   // Second block: first digest, then the fixed padding for a 256-bit message
   assign load_block = pass2 ?
      {h_reg[0], h_reg[1], h_reg[2], h_reg[3], h_reg[4], h_reg[5], h_reg[6], h_reg[7],
       32'h80000000, {6{32'h00000000}}, 32'h00000100} : MSG_BLOCK;
`else
   assign load_block = MSG_BLOCK;
`endif

   // The window always holds W[t..t+15]; the word shifted in is W[t+16]
   assign w_new = ssig1(w_win[14]) + w_win[9] + ssig0(w_win[1]) + w_win[0];

   sha256_round u_round (
      .cur (work),
      .k   (K[ctr]),
      .w   (w_win[0]),
      .nxt (work_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD;
         ctr   <= '0;
         work  <= iv_work();
         for (int i = 0; i < 8; i++)  h_reg[i] <= IV[i];
         for (int i = 0; i < 16; i++) w_win[i] <= '0;
`ifdef SHA256_DOUBLE_HASH_EN
         pass2 <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               // IV reload also clears the first-pass digest when rehashing
               work <= iv_work();
               for (int i = 0; i < 8; i++)  h_reg[i] <= IV[i];
               for (int i = 0; i < 16; i++) w_win[i] <= load_block[511 - 32*i -: 32];
               ctr   <= '0;
               state <= ROUND;
            end
            ROUND: begin
               work <= work_nxt;
               for (int i = 0; i < 15; i++) w_win[i] <= w_win[i+1];
               w_win[15] <= w_new;
               if (ctr == 6'd63) state <= FINAL;
               else              ctr   <= ctr + 6'd1;
            end
            FINAL: begin
               h_reg[0] <= h_reg[0] + work.a;
               h_reg[1] <= h_reg[1] + work.b;
               h_reg[2] <= h_reg[2] + work.c;
               h_reg[3] <= h_reg[3] + work.d;
               h_reg[4] <= h_reg[4] + work.e;
               h_reg[5] <= h_reg[5] + work.f;
               h_reg[6] <= h_reg[6] + work.g;
               h_reg[7] <= h_reg[7] + work.h;
`ifdef SHA256_DOUBLE_HASH_EN
               if (!pass2) begin
                  pass2 <= 1'b1;
                  state <= LOAD;
               end else begin
                  state <= DONE;
               end
`else
               state <= DONE;
`endif
            end
            DONE: begin
               state <= DONE;
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign bus.h1 = h_reg[0];
   assign bus.h2 = h_reg[1];
   assign bus.h3 = h_reg[2];
   assign bus.h4 = h_reg[3];
   assign bus.h5 = h_reg[4];
   assign bus.h6 = h_reg[5];
   assign bus.h7 = h_reg[6];
   assign bus.h8 = h_reg[7];

   assign bus.a_out = work.a;
   assign bus.b_out = work.b;
   assign bus.c_out = work.c;
   assign bus.d_out = work.d;
   assign bus.e_out = work.e;
   assign bus.f_out = work.f;
   assign bus.g_out = work.g;
   assign bus.h_out = work.h;

   assign bus.state     = state;
   assign bus.round_cnt = ctr;

endmodule

// File: tb/tb_sha256_hash_top.sv
// Directed bench for sha256_hash_top: reset values, round snapshots, digest, hold and mid-hash reset.
module tb_sha256_hash_top;
   import sha256_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   logic [255:0] exp_q[$];
   logic [255:0] exp_digest;

   localparam logic [255:0] IV_VEC   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] R0_VEC   = 256'h5d6aebcd_6a09e667_bb67ae85_3c6ef372_fa2a4622_510e527f_9b05688c_1f83d9ab;
   localparam logic [255:0] R63_VEC  = 256'h506e3058_d39a2165_04d24d6c_b85e2ce9_5ef50f24_fb121210_948d25b6_961f4894;
   localparam logic [255:0] ABC_VEC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] ABCD_VEC = 256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;

   sha256_hash_if bus ();

   sha256_hash_top dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver: advance n rising edges, then park on the following falling edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] h_word(input int i);
      case (i)
         0: return bus.h1;
         1: return bus.h2;
         2: return bus.h3;
         3: return bus.h4;
         4: return bus.h5;
         5: return bus.h6;
         6: return bus.h7;
         default: return bus.h8;
      endcase
   endfunction

   function automatic logic [31:0] w_word(input int i);
      case (i)
         0: return bus.a_out;
         1: return bus.b_out;
         2: return bus.c_out;
         3: return bus.d_out;
         4: return bus.e_out;
         5: return bus.f_out;
         6: return bus.g_out;
         default: return bus.h_out;
      endcase
   endfunction

   // Scoreboard checks
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_h(input string tag, input logic [255:0] exp);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s.h%0d", tag, i + 1), h_word(i), exp[255 - 32*i -: 32]);
   endtask

   task automatic chk_work(input string tag, input logic [255:0] exp);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s.work%0d", tag, i), w_word(i), exp[255 - 32*i -: 32]);
   endtask

   task automatic chk_state(input string tag, input state_t exp);
      n_cmp++;
      assert (bus.state === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, bus.state, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
`ifdef SHA256_DOUBLE_HASH_EN
      exp_q.push_back(ABCD_VEC);
`else
      exp_q.push_back(ABC_VEC);
`endif
      exp_q.push_back(ABC_VEC);

      // Reset held with clocks running
      rst = 1'b1;
      step(3);
      chk_h("reset", IV_VEC);
      chk_work("reset", IV_VEC);
      chk_state("reset.state", LOAD);

      // LOAD + round 0
      rst = 1'b0;
      step(2);
      chk_work("round0", R0_VEC);
      chk_h("round0", IV_VEC);

      // After round 63: working vars final, digest not yet added
      step(63);
      chk_work("round63", R63_VEC);
      chk_h("round63", IV_VEC);
      chk_state("round63.state", FINAL);

      step(1);
      chk_h("digest66", ABC_VEC);
`ifdef SHA256_DOUBLE_HASH_EN
      step(1);
      chk_h("pass2_iv", IV_VEC);
      step(65);
`endif
      exp_digest = exp_q.pop_front();
      chk_h("digest_final", exp_digest);
      chk_state("digest_final.state", DONE);

      // DONE holds through extra clocks
      step(200);
      chk_h("hold200", exp_digest);
      chk_work("hold200", R63_VEC);

      // Mid-hash reset: async clear, then full restart
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(30);
      rst = 1'b1;
      #1;
      chk_h("midrst", IV_VEC);
      chk_work("midrst", IV_VEC);
      step(2);
      rst = 1'b0;
      step(66);
      exp_digest = exp_q.pop_front();
      chk_h("restart66", exp_digest);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
